// File: rtl/vga_fb_ctrl.sv
// -----------------------------------------------------------------------------
// vga_fb_ctrl
//
// Parametrised VGA display controller with an internal CPU-writable
// framebuffer. The framebuffer holds one RGB332 byte per entry at a reduced
// resolution (FB_W x FB_H = active area >> SCALE_SHIFT). The display path
// replicates each entry over a 2^SCALE_SHIFT square of screen pixels. A
// hardware clear engine fills the whole framebuffer with one colour, and a
// frame counter plus status bits can be read back over the CPU bus.
//
// Ports
//   CLOCK2_50    in   system clock
//   KEY          in   asynchronous active-low reset
//   ALUResult    in   CPU byte address
//   RD2          in   CPU write data
//   MemWrite     in   write strobe (one cycle per write)
//   MemRead      in   read strobe
//   END          in   CPU program-finished flag (rising edge latches 'done')
//   ReadData     out  read-back data, valid the cycle after MemRead
//   cpu_busy     out  high while the clear engine runs
//   VGA_CLK      out  pixel clock (registered, low when outputs update)
//   VGA_HS/VS    out  active-low syncs
//   VGA_BLANK_N  out  high in the active area
//   VGA_SYNC_N   out  constant 0
//   VGA_R/G/B    out  8-bit colour for the DAC
//
// Address map
//   BASE_ADDR .. BASE_ADDR+FB_W*FB_H-1 : framebuffer, one pixel per byte
//   CTRL_ADDR  write: bit0 enable, bit1 start clear with fill RD2[15:8]
//              read : {frame_count, 13'b0, done, cpu_busy, enable}
// -----------------------------------------------------------------------------
module vga_fb_ctrl #(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter int          CLK_DIV     = 2,
  parameter int          SCALE_SHIFT = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_0FFC
) (
  input  logic        CLOCK2_50,
  input  logic        KEY,
  input  logic [31:0] ALUResult,
  input  logic [31:0] RD2,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        END,
  output logic [31:0] ReadData,
  output logic        cpu_busy,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  // ---------------------------------------------------------------------------
  // Derived geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);
  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H    = V_ACTIVE >> SCALE_SHIFT;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int AW      = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [AW-1:0] FB_LAST  = AW'(FB_SIZE - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_FB, RD_STAT} rd_sel_t;

  // ---------------------------------------------------------------------------
  // Pixel divider and VGA_CLK
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic          pix_en;

  assign pix_en   = (div_cnt == DIV_LAST);
  assign div_next = pix_en ? '0 : div_cnt + 1'b1;

  // VGA_CLK follows the divider phase one clock late, so it is low right after
  // the outputs change and rises half a pixel later, with outputs settled.
  always_ff @(posedge CLOCK2_50 or negedge KEY) begin
    if (!KEY) begin
      div_cnt <= '0;
      VGA_CLK <= 1'b0;
    end else begin
      div_cnt <= div_next;
      VGA_CLK <= (div_next >= DIV_HALF);
    end
  end

  // ---------------------------------------------------------------------------
  // Raster counters and frame counter
  // ---------------------------------------------------------------------------
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [15:0]   frame_count;
  logic          h_wrap;
  logic          v_wrap;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  always_ff @(posedge CLOCK2_50 or negedge KEY) begin
    if (!KEY) begin
      hcnt        <= '0;
      vcnt        <= '0;
      frame_count <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hcnt <= '0;
        if (v_wrap) begin
          vcnt        <= '0;
          frame_count <= frame_count + 1'b1;
        end else begin
          vcnt <= vcnt + 1'b1;
        end
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CPU address decode
  // ---------------------------------------------------------------------------
  logic [31:0] cpu_off;
  logic        fb_hit;
  logic        ctrl_hit;
  logic [AW-1:0] cpu_idx;

  assign cpu_off  = ALUResult - BASE_ADDR;
  assign fb_hit   = (ALUResult >= BASE_ADDR) && (cpu_off < 32'(FB_SIZE));
  assign ctrl_hit = (ALUResult == CTRL_ADDR);
  assign cpu_idx  = cpu_off[AW-1:0];

  // ---------------------------------------------------------------------------
  // Control register, done flag, clear engine
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [AW-1:0] clr_idx;
  logic [7:0]    fill;
  logic          enable;
  logic          done;
  logic          end_d;
  logic          clear_start;

  assign clear_start = MemWrite && ctrl_hit && RD2[1];
  assign cpu_busy    = (state == ST_CLEAR);

  always_ff @(posedge CLOCK2_50 or negedge KEY) begin
    if (!KEY) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (clear_start) state_next = ST_CLEAR;
      ST_CLEAR: if (clr_idx == FB_LAST) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // A clear request while already clearing is dropped: the fill colour and
  // index are only loaded from IDLE.
  always_ff @(posedge CLOCK2_50 or negedge KEY) begin
    if (!KEY) begin
      clr_idx <= '0;
      fill    <= '0;
    end else if (state == ST_IDLE) begin
      if (clear_start) begin
        clr_idx <= '0;
        fill    <= RD2[15:8];
      end
    end else begin
      clr_idx <= clr_idx + 1'b1;
    end
  end

  // The enable bit is writable at any time, including during a clear.
  always_ff @(posedge CLOCK2_50 or negedge KEY) begin
    if (!KEY) begin
      enable <= 1'b0;
      done   <= 1'b0;
      end_d  <= 1'b0;
    end else begin
      end_d <= END;
      if (END && !end_d) done <= 1'b1;
      if (MemWrite && ctrl_hit) enable <= RD2[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Framebuffer: one write port shared by clear engine and CPU, a display read
  // port and a CPU read port. Reads are read-first, so a same-cycle write to
  // the entry being displayed shows the old value.
  // ---------------------------------------------------------------------------
  logic [7:0]    fb_mem [0:FB_SIZE-1];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [AW-1:0] disp_addr;
  logic [7:0]    disp_pix;
  logic [7:0]    cpu_pix;
  logic [HW-SCALE_SHIFT-1:0] fb_x;
  logic [VW-SCALE_SHIFT-1:0] fb_y;

  assign fb_x      = hcnt[HW-1:SCALE_SHIFT];
  assign fb_y      = vcnt[VW-1:SCALE_SHIFT];
  assign disp_addr = AW'(fb_y) * AW'(FB_W) + AW'(fb_x);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cpu_idx;
    mem_wdata = RD2[7:0];
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx;
      mem_wdata = fill;
    end else if (MemWrite && fb_hit) begin
      mem_we = 1'b1;
    end
  end

  // Display data is fetched every clock; counters are stable for at least one
  // clock before each pix_en, so disp_pix always matches the current position.
  always_ff @(posedge CLOCK2_50) begin
    if (mem_we) fb_mem[mem_waddr] <= mem_wdata;
    disp_pix <= fb_mem[disp_addr];
    if (MemRead) cpu_pix <= fb_mem[cpu_idx];
  end

  // ---------------------------------------------------------------------------
  // CPU read-back
  // ---------------------------------------------------------------------------
  rd_sel_t     rd_sel;
  logic [31:0] rd_status;

  always_ff @(posedge CLOCK2_50 or negedge KEY) begin
    if (!KEY) begin
      rd_sel    <= RD_NONE;
      rd_status <= '0;
    end else if (MemRead) begin
      if (fb_hit)        rd_sel <= RD_FB;
      else if (ctrl_hit) rd_sel <= RD_STAT;
      else               rd_sel <= RD_NONE;
      rd_status <= {frame_count, 13'b0, done, cpu_busy, enable};
    end
  end

  always_comb begin
    ReadData = '0;
    case (rd_sel)
      RD_FB:   ReadData = {24'b0, cpu_pix};
      RD_STAT: ReadData = rd_status;
      default: ReadData = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Video output stage: RGB332 expansion and registered syncs/colour
  // ---------------------------------------------------------------------------
  logic [7:0] r8;
  logic [7:0] g8;
  logic [7:0] b8;
  logic       active;

  assign r8     = {disp_pix[7:5], disp_pix[7:5], disp_pix[7:6]};
  assign g8     = {disp_pix[4:2], disp_pix[4:2], disp_pix[4:3]};
  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);

  for (genvar gi = 0; gi < 4; gi++) begin : g_b_rep
    assign b8[2*gi +: 2] = disp_pix[1:0];
  end

  // Registered on the same pix_en that advances the counters, so every video
  // output lags the raster counters by exactly one pixel.
  always_ff @(posedge CLOCK2_50 or negedge KEY) begin
    if (!KEY) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_en) begin
      VGA_HS      <= !((hcnt >= HS_START) && (hcnt < HS_END));
      VGA_VS      <= !((vcnt >= VS_START) && (vcnt < VS_END));
      VGA_BLANK_N <= active;
      VGA_R       <= (active && enable) ? r8 : 8'h00;
      VGA_G       <= (active && enable) ? g8 : 8'h00;
      VGA_B       <= (active && enable) ? b8 : 8'h00;
    end
  end

  assign VGA_SYNC_N = 1'b0;

  // RD2[31:16] carries no information for this block.
  logic unused_rd2;
  assign unused_rd2 = ^RD2[31:16];

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_ctrl
//
// Bench for vga_fb_ctrl on a reduced raster (32x16 active, 48x24 total,
// 8x4 framebuffer) so that several frames fit in a short run. A table of
// CPU bus vectors covers register/framebuffer access; hand-written sequences
// cover sync timing, displayed pixels, the clear engine and reset mid-clear.
// -----------------------------------------------------------------------------
module tb_vga_fb_ctrl;

  localparam int          HA = 32, HFP = 4, HSY = 8, HBP = 4;
  localparam int          VA = 16, VFP = 2, VSY = 2, VBP = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] CTRL = 32'h0000_0FFC;
  localparam int          FBN  = 32;
  localparam int          NV   = 13;

  logic        clk = 1'b0;
  logic        key = 1'b0;
  logic [31:0] alu = '0;
  logic [31:0] rd2 = '0;
  logic        mem_write = 1'b0;
  logic        mem_read  = 1'b0;
  logic        end_flag  = 1'b0;

  logic [31:0] read_data;
  logic        cpu_busy, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_fb_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CLK_DIV(2), .SCALE_SHIFT(2), .BASE_ADDR(BASE), .CTRL_ADDR(CTRL)
  ) dut (
    .CLOCK2_50(clk), .KEY(key), .ALUResult(alu), .RD2(rd2),
    .MemWrite(mem_write), .MemRead(mem_read), .END(end_flag),
    .ReadData(read_data), .cpu_busy(cpu_busy), .VGA_CLK(vga_clk),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n),
    .VGA_SYNC_N(vga_sync_n), .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  int busy_total = 0;
  bit sync_n_high = 1'b0;
  always @(negedge clk) begin
    if (cpu_busy) busy_total <= busy_total + 1;
    if (vga_sync_n !== 1'b0) sync_n_high <= 1'b1;
  end

  // Screen capture located purely from the sync/blank outputs: VS falling
  // starts a new frame, each BLANK_N rise starts the next visible row.
  logic [23:0] cap [0:VA-1][0:HA-1];
  int cap_row = 100;
  int cap_col = 0;
  bit prev_vs = 1'b1;
  bit prev_blank = 1'b0;
  always @(posedge vga_clk) begin
    prev_vs    <= vga_vs;
    prev_blank <= vga_blank_n;
    if (prev_vs && !vga_vs) begin
      cap_row <= -1;
    end else if (vga_blank_n && !prev_blank) begin
      cap_row <= cap_row + 1;
      cap_col <= 1;
      if (cap_row + 1 >= 0 && cap_row + 1 < VA) cap[cap_row+1][0] <= {vga_r, vga_g, vga_b};
    end else if (vga_blank_n) begin
      cap_col <= cap_col + 1;
      if (cap_row >= 0 && cap_row < VA && cap_col < HA) cap[cap_row][cap_col] <= {vga_r, vga_g, vga_b};
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    alu = a; rd2 = d; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    alu = a; mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    d = read_data;
  endtask

  function automatic logic sync_sig(input bit use_vs);
    return use_vs ? vga_vs : vga_hs;
  endfunction

  // Period and low width (in system clocks) of HS or VS, measured from one
  // falling edge to the next. Zero on timeout.
  task automatic measure(input bit use_vs, output int per, output int low);
    logic prev, cur;
    bit   found;
    per = 0; low = 0; found = 1'b0;
    prev = sync_sig(use_vs);
    for (int n = 0; n < 5000 && !found; n++) begin
      @(negedge clk);
      cur = sync_sig(use_vs);
      if (prev && !cur) found = 1'b1;
      prev = cur;
    end
    if (!found) return;
    per = 1; low = 1; found = 1'b0;
    for (int n = 0; n < 5000 && !found; n++) begin
      @(negedge clk);
      cur = sync_sig(use_vs);
      if (prev && !cur) found = 1'b1;
      else begin
        per++;
        if (!cur) low++;
      end
      prev = cur;
    end
    if (!found) begin per = 0; low = 0; end
  endtask

  task automatic wait_vs_fall();
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = vga_vs;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      if (prev && !vga_vs) found = 1'b1;
      prev = vga_vs;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL vs_wait: got no VS falling edge, expected one within 3000 clocks");
    end
  endtask

  task automatic check_pix(input int r, input int c, input logic [23:0] exp);
    check($sformatf("pix_r%0d_c%0d", r, c), {8'h00, cap[r][c]}, {8'h00, exp});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    logic [15:0] f0, f1;
    int per, low, b0;
    bit idle;

    //           wr    addr              data          mask           exp
    vecs[0]  = '{1'b1, CTRL,             32'h0000_0001, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, BASE,             32'h0000_00E0, 32'h0,         32'h0};
    vecs[2]  = '{1'b1, BASE + 32'd1,     32'h0000_001C, 32'h0,         32'h0};
    vecs[3]  = '{1'b1, BASE + 32'd31,    32'h0000_0003, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, BASE + 32'd32,    32'h0000_00FF, 32'h0,         32'h0};
    vecs[5]  = '{1'b1, BASE - 32'd1,     32'h0000_0012, 32'h0,         32'h0};
    vecs[6]  = '{1'b0, BASE,             32'h0,         32'hFFFF_FFFF, 32'h0000_00E0};
    vecs[7]  = '{1'b0, BASE + 32'd1,     32'h0,         32'hFFFF_FFFF, 32'h0000_001C};
    vecs[8]  = '{1'b0, BASE + 32'd31,    32'h0,         32'hFFFF_FFFF, 32'h0000_0003};
    vecs[9]  = '{1'b0, BASE + 32'd32,    32'h0,         32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{1'b0, BASE - 32'd1,     32'h0,         32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{1'b0, 32'h0000_2000,    32'h0,         32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{1'b0, CTRL,             32'h0,         32'h0000_FFFF, 32'h0000_0001};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_readdata", read_data, 32'h0);
    check("rst_busy",     {31'b0, cpu_busy}, 32'h0);
    check("rst_hs_vs",    {30'b0, vga_hs, vga_vs}, 32'h3);
    check("rst_blank_n",  {31'b0, vga_blank_n}, 32'h0);
    check("rst_rgb",      {8'h00, vga_r, vga_g, vga_b}, 32'h0);
    check("rst_vga_clk",  {31'b0, vga_clk}, 32'h0);
    key = 1'b1;

    // Sync timing: 48 px lines, 8 px HS; 24 line frames, 2 line VS
    measure(1'b0, per, low);
    check("hs_period", per, 32'd96);
    check("hs_low",    low, 32'd16);
    measure(1'b1, per, low);
    check("vs_period", per, 32'd2304);
    check("vs_low",    low, 32'd192);

    // Register / framebuffer vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        cpu_write(vecs[i].addr, vecs[i].data);
        $display("     vec%0d write %h <= %h", i, vecs[i].addr, vecs[i].data);
      end else begin
        cpu_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_read_%h", i, vecs[i].addr), rd & vecs[i].mask, vecs[i].exp);
      end
    end

    // Displayed pixels: entry 0 red over a 4x4 block, entry 1 green, last blue
    wait_vs_fall();
    wait_vs_fall();
    check_pix(0, 0,   24'hFF0000);
    check_pix(3, 3,   24'hFF0000);
    check_pix(0, 4,   24'h00FF00);
    check_pix(15, 31, 24'h0000FF);
    check_pix(12, 28, 24'h0000FF);

    // Clear engine with dropped writes and an enable change while clearing
    b0 = busy_total;
    cpu_write(CTRL, 32'h0000_1C03);
    repeat (8) @(negedge clk);
    cpu_write(BASE, 32'h0000_0055);
    cpu_write(CTRL, 32'h0000_AA02);
    idle = 1'b0;
    for (int n = 0; n < 200 && !idle; n++) begin
      @(negedge clk);
      if (!cpu_busy) idle = 1'b1;
    end
    check("clear_terminates", {31'b0, idle}, 32'h1);
    @(negedge clk);
    check("clear_busy_cycles", busy_total - b0, 32'd32);
    cpu_read(CTRL, rd);
    check("ctrl_after_clear", rd & 32'h7, 32'h0);
    for (int i = 0; i < FBN; i++) begin
      cpu_read(BASE + 32'(i), rd);
      check($sformatf("clear_fill_%0d", i), rd, 32'h0000_001C);
    end

    // END rising edge together with a control write: both take effect
    @(negedge clk);
    alu = CTRL; rd2 = 32'h1; mem_write = 1'b1; end_flag = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    repeat (3) @(negedge clk);
    end_flag = 1'b0;
    cpu_read(CTRL, rd);
    check("ctrl_done_enable", rd & 32'h7, 32'h5);

    // Frame counter advances once per frame
    wait_vs_fall();
    cpu_read(CTRL, rd);
    f0 = rd[31:16];
    wait_vs_fall();
    wait_vs_fall();
    wait_vs_fall();
    cpu_read(CTRL, rd);
    f1 = rd[31:16];
    check("frame_delta", {16'h0, f1 - f0}, 32'd3);
    check_pix(0, 0,   24'h00FF00);
    check_pix(15, 31, 24'h00FF00);

    // Disabled display: black pixels, syncs keep running
    cpu_write(CTRL, 32'h0);
    wait_vs_fall();
    wait_vs_fall();
    check_pix(0, 0,  24'h000000);
    check_pix(8, 16, 24'h000000);
    measure(1'b0, per, low);
    check("hs_period_disabled", per, 32'd96);

    // Reset in the middle of a clear
    cpu_write(CTRL, 32'h0000_3303);
    repeat (9) @(negedge clk);
    key = 1'b0;
    #1;
    check("midclr_busy_now", {31'b0, cpu_busy}, 32'h0);
    check("midclr_readdata", read_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    key = 1'b1;
    @(negedge clk);
    check("midclr_busy_after", {31'b0, cpu_busy}, 32'h0);
    cpu_write(BASE + 32'd2, 32'h0000_0077);
    cpu_read(BASE + 32'd2, rd);
    check("midclr_write_ok", rd, 32'h0000_0077);
    cpu_read(BASE, rd);
    check("midclr_entry0", rd, 32'h0000_0033);
    cpu_read(BASE + 32'd31, rd);
    check("midclr_entry31", rd, 32'h0000_001C);

    check("sync_n_low", {31'b0, sync_n_high}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
